// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - state encodings, opcode/funct constants and control codes for the multicycle control unit
package mc_ctrl_pkg;

    typedef enum logic [4:0] {
        S_RESET      = 5'd0,
        S_FETCH      = 5'd1,
        S_FETCH_WAIT = 5'd2,
        S_DECODE     = 5'd3,
        S_EXEC_R     = 5'd4,
        S_WB_R       = 5'd5,
        S_SHIFT_LD   = 5'd6,
        S_SHIFT_OP   = 5'd7,
        S_SHIFT_WB   = 5'd8,
        S_ADDI       = 5'd9,
        S_WB_I       = 5'd10,
        S_ADDR       = 5'd11,
        S_MEM_RD     = 5'd12,
        S_MEM_WAIT   = 5'd13,
        S_WB_LW      = 5'd14,
        S_MEM_WR     = 5'd15,
        S_BEQ        = 5'd16,
        S_BNE        = 5'd17,
        S_JUMP       = 5'd18,
        S_JR         = 5'd19,
        S_EXC_SAVE   = 5'd20,
        S_EXC_RD     = 5'd21,
        S_EXC_WAIT   = 5'd22,
        S_EXC_LOAD   = 5'd23
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;

    localparam logic [2:0] SH_HOLD = 3'b000;
    localparam logic [2:0] SH_LOAD = 3'b001;
    localparam logic [2:0] SH_SLL  = 3'b010;
    localparam logic [2:0] SH_SRL  = 3'b011;

    localparam logic [3:0] SRCB_B        = 4'd0;
    localparam logic [3:0] SRCB_FOUR     = 4'd1;
    localparam logic [3:0] SRCB_SEXT     = 4'd2;
    localparam logic [3:0] SRCB_SEXT_SH2 = 4'd3;

    localparam logic [3:0] PCS_ALU    = 4'd0;
    localparam logic [3:0] PCS_ALUOUT = 4'd1;
    localparam logic [3:0] PCS_JUMP   = 4'd2;
    localparam logic [3:0] PCS_VEC    = 4'd4;

    localparam logic [3:0] EXC_NONE   = 4'd0;
    localparam logic [3:0] EXC_OPCODE = 4'd1;
    localparam logic [3:0] EXC_OVF    = 4'd2;

    // Instruction dispatch out of DECODE; unknown encodings go to the exception path.
    function automatic state_t decode_state(input logic [5:0] opcode, input logic [5:0] funct);
        state_t s;
        s = S_EXC_SAVE;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD, FN_SUB, FN_AND: s = S_EXEC_R;
                    FN_SLL, FN_SRL:         s = S_SHIFT_LD;
                    FN_JR:                  s = S_JR;
                    default:                s = S_EXC_SAVE;
                endcase
            end
            OP_ADDI:      s = S_ADDI;
            OP_LW, OP_SW: s = S_ADDR;
            OP_BEQ:       s = S_BEQ;
            OP_BNE:       s = S_BNE;
            OP_J:         s = S_JUMP;
            default:      s = S_EXC_SAVE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mc_wait_counter.sv
// rtl/mc_wait_counter.sv - load/decrement memory latency counter with zero flag
module mc_wait_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [2:0] count;

    // Saturates at zero so a wait state that exits on zero leaves it parked there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= 3'd0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != 3'd0)) begin
            count <= count - 3'd1;
        end
    end

    assign zero = (count == 3'd0);

endmodule

// File: rtl/mc_control_unit.sv
// rtl/mc_control_unit.sv - main control FSM of the multicycle MIPS-subset CPU
import mc_ctrl_pkg::*;

module mc_control_unit #(
    parameter int         MEM_LAT    = 2,
    parameter logic [7:0] VEC_OPCODE = 8'd253,
    parameter logic [7:0] VEC_OVF    = 8'd254
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    input  logic       Overflow,
    input  logic       Zero,
    input  logic       Igual,
    output logic       PCwrite,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       EPCWrite,
    output logic       MemToReg,
    output logic       RegDest,
    output logic       AluSrcA,
    output logic       IorD,
    output logic [3:0] AluSrcB,
    output logic [3:0] PCSource,
    output logic [2:0] ALUControl,
    output logic [2:0] ShiftControl,
    output logic [3:0] Exception,
    output logic [4:0] state_dbg
);

    localparam logic [2:0] WAIT_INIT = 3'(MEM_LAT - 1);

    state_t     state, next_state;
    logic [3:0] exc_code, exc_next;
    logic       exc_set, cnt_load, cnt_dec, cnt_zero;

    // Vector addresses are decoded by the datapath from the Exception code.
    logic unused_ok;
    assign unused_ok = &{1'b0, Zero, VEC_OPCODE, VEC_OVF};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_RESET;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exc_code <= EXC_NONE;
        end else if (exc_set) begin
            exc_code <= exc_next;
        end else if (state == S_EXC_LOAD) begin
            exc_code <= EXC_NONE;
        end
    end

    mc_wait_counter u_wait (
        .clk      (clk),
        .rst_n    (reset),
        .load     (cnt_load),
        .load_val (WAIT_INIT),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign state_dbg = state;

    always_comb begin
        next_state   = state;
        PCwrite      = 1'b0;
        MemWrite     = 1'b0;
        MemRead      = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        EPCWrite     = 1'b0;
        MemToReg     = 1'b0;
        RegDest      = 1'b0;
        AluSrcA      = 1'b0;
        IorD         = 1'b0;
        AluSrcB      = SRCB_B;
        PCSource     = PCS_ALU;
        ALUControl   = ALU_PASS;
        ShiftControl = SH_HOLD;
        Exception    = EXC_NONE;
        exc_set      = 1'b0;
        exc_next     = EXC_NONE;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        case (state)
            S_RESET: next_state = S_FETCH;
            S_FETCH: begin
                AluSrcB    = SRCB_FOUR;
                ALUControl = ALU_ADD;
                PCwrite    = 1'b1;
                cnt_load   = 1'b1;
                next_state = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    IRWrite    = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                AluSrcB    = SRCB_SEXT_SH2;
                ALUControl = ALU_ADD;
                next_state = decode_state(OPCODE, FUNCT);
                if (next_state == S_EXC_SAVE) begin
                    exc_set  = 1'b1;
                    exc_next = EXC_OPCODE;
                end
            end
            S_EXEC_R: begin
                AluSrcA = 1'b1;
                case (FUNCT)
                    FN_SUB:  ALUControl = ALU_SUB;
                    FN_AND:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
                if ((FUNCT != FN_AND) && Overflow) begin
                    exc_set    = 1'b1;
                    exc_next   = EXC_OVF;
                    next_state = S_EXC_SAVE;
                end else begin
                    next_state = S_WB_R;
                end
            end
            S_WB_R, S_SHIFT_WB: begin
                RegDest    = 1'b1;
                RegWrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_SHIFT_LD: begin
                ShiftControl = SH_LOAD;
                next_state   = S_SHIFT_OP;
            end
            S_SHIFT_OP: begin
                ShiftControl = (FUNCT == FN_SRL) ? SH_SRL : SH_SLL;
                next_state   = S_SHIFT_WB;
            end
            S_ADDI: begin
                AluSrcA    = 1'b1;
                AluSrcB    = SRCB_SEXT;
                ALUControl = ALU_ADD;
                if (Overflow) begin
                    exc_set    = 1'b1;
                    exc_next   = EXC_OVF;
                    next_state = S_EXC_SAVE;
                end else begin
                    next_state = S_WB_I;
                end
            end
            S_WB_I: begin
                RegWrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_ADDR: begin
                AluSrcA    = 1'b1;
                AluSrcB    = SRCB_SEXT;
                ALUControl = ALU_ADD;
                next_state = (OPCODE == OP_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                IorD       = 1'b1;
                cnt_load   = 1'b1;
                next_state = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                IorD    = 1'b1;
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    MemRead    = 1'b1;
                    next_state = S_WB_LW;
                end
            end
            S_WB_LW: begin
                MemToReg   = 1'b1;
                RegWrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_WR: begin
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_BEQ, S_BNE: begin
                AluSrcA    = 1'b1;
                ALUControl = ALU_SUB;
                PCSource   = PCS_ALUOUT;
                PCwrite    = (state == S_BEQ) ? Igual : !Igual;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                PCSource   = PCS_JUMP;
                PCwrite    = 1'b1;
                next_state = S_FETCH;
            end
            S_JR: begin
                AluSrcA    = 1'b1;
                PCwrite    = 1'b1;
                next_state = S_FETCH;
            end
            S_EXC_SAVE: begin
                AluSrcB    = SRCB_FOUR;
                ALUControl = ALU_SUB;
                EPCWrite   = 1'b1;
                next_state = S_EXC_RD;
            end
            S_EXC_RD: begin
                IorD       = 1'b1;
                Exception  = exc_code;
                cnt_load   = 1'b1;
                next_state = S_EXC_WAIT;
            end
            S_EXC_WAIT: begin
                IorD      = 1'b1;
                Exception = exc_code;
                cnt_dec   = 1'b1;
                if (cnt_zero) begin
                    MemRead    = 1'b1;
                    next_state = S_EXC_LOAD;
                end
            end
            S_EXC_LOAD: begin
                PCSource   = PCS_VEC;
                PCwrite    = 1'b1;
                next_state = S_FETCH;
            end
            default: next_state = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// tb/tb_mc_control_unit.sv - randomized instruction-level bench for mc_control_unit against a per-instruction event model
module tb_mc_control_unit;
    import mc_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] OPCODE, FUNCT;
    logic       Overflow, Zero, Igual;

    logic       pcw [2], mw [2], mr [2], irw [2], rw [2], epcw [2];
    logic       mtr [2], rdst [2], asa [2], iord [2];
    logic [3:0] asb [2], pcs [2], exc [2];
    logic [2:0] aluc [2], shc [2];
    logic [4:0] st [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mc_control_unit #(.MEM_LAT(2)) u_dut (
        .clk(clk), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT),
        .Overflow(Overflow), .Zero(Zero), .Igual(Igual),
        .PCwrite(pcw[0]), .MemWrite(mw[0]), .MemRead(mr[0]), .IRWrite(irw[0]),
        .RegWrite(rw[0]), .EPCWrite(epcw[0]), .MemToReg(mtr[0]), .RegDest(rdst[0]),
        .AluSrcA(asa[0]), .IorD(iord[0]), .AluSrcB(asb[0]), .PCSource(pcs[0]),
        .ALUControl(aluc[0]), .ShiftControl(shc[0]), .Exception(exc[0]), .state_dbg(st[0])
    );

    mc_control_unit #(.MEM_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT),
        .Overflow(Overflow), .Zero(Zero), .Igual(Igual),
        .PCwrite(pcw[1]), .MemWrite(mw[1]), .MemRead(mr[1]), .IRWrite(irw[1]),
        .RegWrite(rw[1]), .EPCWrite(epcw[1]), .MemToReg(mtr[1]), .RegDest(rdst[1]),
        .AluSrcA(asa[1]), .IorD(iord[1]), .AluSrcB(asb[1]), .PCSource(pcs[1]),
        .ALUControl(aluc[1]), .ShiftControl(shc[1]), .Exception(exc[1]), .state_dbg(st[1])
    );

    typedef enum int {K_ALU, K_SHIFT, K_JR, K_ADDI, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_BAD} kind_t;

    typedef struct {
        int cycles, irw_idx, rw, rdst, mtr, mr, mr_idx, mw, epc, pcw, pcsrc, exc_cyc, exc_code;
    } ev_t;

    logic [5:0] op_pool [9] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02};
    logic [5:0] fn_pool [6] = '{6'h20, 6'h22, 6'h24, 6'h00, 6'h02, 6'h08};

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int outs_or(input int d);
        return int'({pcw[d], mw[d], mr[d], irw[d], rw[d], epcw[d], mtr[d], rdst[d], asa[d],
                     iord[d], asb[d], pcs[d], exc[d], aluc[d], shc[d]});
    endfunction

    function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'h00) begin
            if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24) return K_ALU;
            if (fn == 6'h00 || fn == 6'h02) return K_SHIFT;
            if (fn == 6'h08) return K_JR;
            return K_BAD;
        end
        if (op == 6'h08) return K_ADDI;
        if (op == 6'h23) return K_LW;
        if (op == 6'h2b) return K_SW;
        if (op == 6'h04) return K_BEQ;
        if (op == 6'h05) return K_BNE;
        if (op == 6'h02) return K_J;
        return K_BAD;
    endfunction

    // Cycle indices count from the FETCH cycle (index 0); DECODE sits at lat+1.
    function automatic ev_t model(input int lat, input logic [5:0] op, input logic [5:0] fn,
                                  input logic ig, input logic ov);
        ev_t   e;
        int    b, s;
        kind_t k;
        e = '{default: 0};
        e.irw_idx = lat;
        e.mr_idx  = -1;
        e.pcw     = 1;
        b = lat + 1;
        s = -1;
        k = classify(op, fn);
        case (k)
            K_ALU: begin
                if (fn != 6'h24 && ov) s = b + 2;
                else begin e.cycles = b + 3; e.rw = 1; e.rdst = 1; end
            end
            K_SHIFT: begin e.cycles = b + 4; e.rw = 1; e.rdst = 1; end
            K_JR:    begin e.cycles = b + 2; e.pcw = 2; end
            K_ADDI: begin
                if (ov) s = b + 2;
                else begin e.cycles = b + 3; e.rw = 1; end
            end
            K_LW: begin
                e.cycles = b + 4 + lat; e.mr = 1; e.mr_idx = b + 2 + lat; e.rw = 1; e.mtr = 1;
            end
            K_SW: begin e.cycles = b + 3; e.mw = 1; end
            K_BEQ, K_BNE: begin
                e.cycles = b + 2;
                if ((k == K_BEQ) ? ig : !ig) begin e.pcw = 2; e.pcsrc = 1; end
            end
            K_J:     begin e.cycles = b + 2; e.pcw = 2; e.pcsrc = 2; end
            default: s = b + 1;
        endcase
        if (s >= 0) begin
            e.epc      = 1;
            e.mr       = 1;
            e.mr_idx   = s + 1 + lat;
            e.exc_cyc  = lat + 1;
            e.exc_code = (k == K_BAD) ? 1 : 2;
            e.pcw      = 2;
            e.pcsrc    = 4;
            e.cycles   = s + 3 + lat;
        end
        return e;
    endfunction

    // Entered at a negedge with DUT d in FETCH; returns at the negedge of the next FETCH.
    task automatic run_instr(input int d, input int lat, input logic [5:0] op, input logic [5:0] fn,
                             input logic ig, input logic ov, input string tag);
        ev_t e, o;
        int  idx, bad_iord, multi;
        check({tag, ":start"}, int'(st[d]), int'(S_FETCH));
        OPCODE = op; FUNCT = fn; Igual = ig; Overflow = ov;
        e = model(lat, op, fn, ig, ov);
        o = '{default: 0};
        o.irw_idx = -1;
        o.mr_idx  = -1;
        bad_iord = 0;
        multi = 0;
        idx = 0;
        do begin
            if (irw[d] && o.irw_idx < 0) o.irw_idx = idx;
            if (rw[d]) begin o.rw++; o.rdst = int'(rdst[d]); o.mtr = int'(mtr[d]); end
            if (mr[d]) begin o.mr++; o.mr_idx = idx; end
            if (mw[d]) o.mw++;
            if (epcw[d]) o.epc++;
            if (pcw[d]) begin o.pcw++; o.pcsrc = int'(pcs[d]); end
            if (exc[d] != 4'd0) begin
                o.exc_cyc++;
                o.exc_code = int'(exc[d]);
                if (!iord[d]) bad_iord++;
            end
            if (int'(rw[d]) + int'(mw[d]) + int'(epcw[d]) > 1) multi++;
            @(negedge clk);
            idx++;
        end while (st[d] != 5'(S_FETCH) && idx < 64);
        o.cycles = idx;
        check({tag, ":cycles"}, o.cycles, e.cycles);
        check({tag, ":irw_idx"}, o.irw_idx, e.irw_idx);
        check({tag, ":regwrite"}, o.rw, e.rw);
        if (e.rw != 0) begin
            check({tag, ":regdest"}, o.rdst, e.rdst);
            check({tag, ":memtoreg"}, o.mtr, e.mtr);
        end
        check({tag, ":memread"}, o.mr, e.mr);
        check({tag, ":memread_idx"}, o.mr_idx, e.mr_idx);
        check({tag, ":memwrite"}, o.mw, e.mw);
        check({tag, ":epcwrite"}, o.epc, e.epc);
        check({tag, ":pcwrite"}, o.pcw, e.pcw);
        check({tag, ":pcsource"}, o.pcsrc, e.pcsrc);
        check({tag, ":exc_cycles"}, o.exc_cyc, e.exc_cyc);
        check({tag, ":exc_code"}, o.exc_code, e.exc_code);
        check({tag, ":exc_iord"}, bad_iord, 0);
        check({tag, ":one_write"}, multi, 0);
    endtask

    task automatic run_random(input int d, input int lat, input int n);
        logic [5:0] op, fn;
        for (int i = 0; i < n; i++) begin
            op = ($urandom_range(0, 2) == 0) ? 6'($urandom) : op_pool[$urandom_range(0, 8)];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_pool[$urandom_range(0, 5)];
            run_instr(d, lat, op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd");
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        OPCODE = 6'h00; FUNCT = 6'h00; Overflow = 1'b0; Zero = 1'b0; Igual = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_state", int'(st[0]), int'(S_RESET));
        check("rst_outs", outs_or(0), 0);
        check("rst_outs1", outs_or(1), 0);
        reset = 1'b1;
        @(negedge clk);

        run_instr(0, 2, 6'h00, 6'h20, 1'b0, 1'b0, "add");
        run_instr(0, 2, 6'h00, 6'h22, 1'b0, 1'b1, "sub_ovf");
        run_instr(0, 2, 6'h00, 6'h24, 1'b0, 1'b1, "and_ovf");
        run_instr(0, 2, 6'h23, 6'h00, 1'b0, 1'b1, "lw");
        run_instr(0, 2, 6'h2b, 6'h00, 1'b0, 1'b0, "sw");
        run_instr(0, 2, 6'h04, 6'h00, 1'b1, 1'b0, "beq_t");
        run_instr(0, 2, 6'h04, 6'h00, 1'b0, 1'b0, "beq_n");
        run_instr(0, 2, 6'h05, 6'h00, 1'b1, 1'b0, "bne_n");
        run_instr(0, 2, 6'h05, 6'h00, 1'b0, 1'b0, "bne_t");
        run_instr(0, 2, 6'h3f, 6'h00, 1'b0, 1'b0, "bad_op");
        run_instr(0, 2, 6'h08, 6'h00, 1'b0, 1'b1, "addi_ovf");
        run_instr(0, 2, 6'h08, 6'h00, 1'b0, 1'b0, "addi");
        run_instr(0, 2, 6'h00, 6'h00, 1'b0, 1'b0, "sll");
        run_instr(0, 2, 6'h00, 6'h02, 1'b0, 1'b0, "srl");
        run_instr(0, 2, 6'h00, 6'h08, 1'b0, 1'b0, "jr");
        run_instr(0, 2, 6'h02, 6'h00, 1'b0, 1'b0, "j");
        run_random(0, 2, 80);

        OPCODE = 6'h00; FUNCT = 6'h20; Overflow = 1'b0;
        n = 0;
        while (st[0] != 5'(S_EXEC_R) && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("reach_exec_r", int'(st[0]), int'(S_EXEC_R));
        reset = 1'b0;
        #1;
        check("mid_rst_state", int'(st[0]), int'(S_RESET));
        check("mid_rst_outs", outs_or(0), 0);
        @(negedge clk);
        reset = 1'b1;
        check("rel_state", int'(st[0]), int'(S_RESET));
        @(negedge clk);
        run_instr(0, 2, 6'h00, 6'h20, 1'b0, 1'b0, "add_after_rst");

        pulse_reset();
        run_instr(1, 1, 6'h00, 6'h20, 1'b0, 1'b0, "add_lat1");
        run_instr(1, 1, 6'h23, 6'h00, 1'b0, 1'b0, "lw_lat1");
        run_instr(1, 1, 6'h3f, 6'h00, 1'b0, 1'b0, "bad_lat1");
        run_random(1, 1, 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
- Main control FSM of the multicycle MIPS-subset CPU; sits directly upstream of the datapath and drives every datapath control wire.
- Consumes OPCODE/FUNCT from the instruction register and the ALU flags; produces per-cycle mux selects, register-load enables, memory write, ALU and shifter commands.
- Handles memory read latency with a wait counter, and handles invalid-opcode and overflow exceptions, including the EPC save and vector load.

Parameters:
- MEM_LAT, 2, memory read latency in cycles; wait states inserted after each address issue (range 1..7).
- VEC_OPCODE, 8'd253, byte address holding the invalid-opcode handler vector.
- VEC_OVF, 8'd254, byte address holding the overflow handler vector.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- OPCODE  in  6  instruction[31:26].
- FUNCT  in  6  instruction[5:0].
- Overflow, Zero, Igual  in  1 each  ALU flags, combinational from the current ALU operation.
- PCwrite, MemWrite, MemRead, IRWrite, RegWrite, EPCWrite  out  1 each  load/write enables.
- MemToReg, RegDest, AluSrcA, IorD  out  1 each  mux selects.
- AluSrcB  out  4  0=B, 1=const 4, 2=SignExt, 3=SignExt<<2.
- PCSource  out  4  0=ALUResult, 1=ALUout, 2=jump target, 3=EPC, 4=MemRegout (exception vector).
- ALUControl  out  3  000 pass A, 001 add, 010 sub, 011 and.
- ShiftControl  out  3  000 hold, 001 load, 010 sll, 011 srl.
- Exception  out  4  0=none, 1=VEC_OPCODE, 2=VEC_OVF; selects the memory address while IorD=1 in exception states.
- state_dbg  out  5  current state encoding, for the bench.

Behaviour:
- Reset: state=RESET; all outputs 0; wait counter 0. Asynchronous, so it takes effect mid-instruction with no partial writes completed after assertion.
- Outputs are Moore (a function of state only). The one exception is PCwrite in BEQ/BNE, which is state AND flag.
- RESET (1 cycle) -> FETCH.
- FETCH:
  - IorD=0; AluSrcA=0; AluSrcB=1; ALUControl=add; PCSource=0; PCwrite=1.
  - Loads counter = MEM_LAT-1; -> FETCH_WAIT.
- FETCH_WAIT:
  - Counter decrements each cycle.
  - When counter==0: IRWrite=1 -> DECODE.
- DECODE:
  - AluSrcA=0; AluSrcB=3; ALUControl=add (branch target into ALUout).
  - Dispatch on OPCODE:
    - 0x00, FUNCT 0x20/0x22/0x24 -> EXEC_R.
    - 0x00, FUNCT 0x00/0x02 -> SHIFT_LD.
    - 0x00, FUNCT 0x08 -> JR.
    - 0x08 -> ADDI.
    - 0x23/0x2b -> ADDR.
    - 0x04 -> BEQ; 0x05 -> BNE.
    - 0x02 -> JUMP.
    - Anything else -> EXC_SAVE with Exception code 1.
- EXEC_R:
  - AluSrcA=1; AluSrcB=0; ALUControl per FUNCT.
  - If add/sub and Overflow -> EXC_SAVE (code 2); else -> WB_R.
- WB_R: RegDest=1; MemToReg=0; RegWrite=1 -> FETCH.
- SHIFT_LD: ShiftControl=001 -> SHIFT_OP.
- SHIFT_OP: ShiftControl=010 or 011 per FUNCT -> SHIFT_WB.
- SHIFT_WB: RegWrite=1; RegDest=1; WriteSrc select shifter -> FETCH.
- ADDI:
  - AluSrcA=1; AluSrcB=2; add.
  - Overflow -> EXC_SAVE (code 2); else -> WB_I.
- WB_I: RegDest=0; RegWrite=1 -> FETCH.
- ADDR:
  - AluSrcA=1; AluSrcB=2; add.
  - lw -> MEM_RD; sw -> MEM_WR.
- MEM_RD: IorD=1; Exception=0; load counter -> MEM_WAIT.
- MEM_WAIT: counter==0 -> MemRead=1 (MDR load) -> WB_LW.
- WB_LW: MemToReg=1; RegDest=0; RegWrite=1 -> FETCH.
- MEM_WR: IorD=1; MemWrite=1 for exactly 1 cycle -> FETCH.
- BEQ/BNE:
  - AluSrcA=1; AluSrcB=0; sub; PCSource=1.
  - PCwrite = Igual (BEQ) or !Igual (BNE) -> FETCH.
- JUMP: PCSource=2; PCwrite=1 -> FETCH.
- JR: AluSrcA=1; ALUControl=pass A; PCSource=0; PCwrite=1 -> FETCH.
- EXC_SAVE:
  - AluSrcA=0; AluSrcB=1; sub (PC-4); EPC source = ALUResult.
  - EPCWrite=1; latch exception code internally -> EXC_RD.
- EXC_RD: IorD=1; Exception=latched code; load counter -> EXC_WAIT.
- EXC_WAIT: counter==0 -> MemRead=1 -> EXC_LOAD.
- EXC_LOAD: PCSource=4; PCwrite=1; clear code -> FETCH.
- Counter is 3 bits. With MEM_LAT=1 it loads 0, so exactly one wait cycle.
- Only one write-enable among RegWrite/MemWrite/EPCWrite is high in any cycle.
- Overflow is ignored in every state except EXEC_R (add/sub) and ADDI.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - state encodings;
  - opcode/funct constants;
  - ALUControl, ShiftControl, AluSrcB and PCSource codes;
  - exception codes.
- Sub-module mc_wait_counter holds the load/decrement/zero-flag latency counter, reused for the fetch, load and exception reads.

Test Plan:
- Reset low mid-EXEC_R -> next sample state=RESET, all outputs 0; after release: RESET, then FETCH, 2 FETCH_WAIT cycles, then IRWrite=1.
- add (OPCODE 0, FUNCT 0x20), Overflow=0 -> state sequence FETCH, FETCH_WAIT×2, DECODE, EXEC_R, WB_R; RegWrite=1, RegDest=1 only in WB_R; 6 cycles total.
- lw (0x23) -> MemRead high exactly once, in the cycle after the MEM_WAIT count reaches 0; WB_LW has MemToReg=1; sw (0x2b) -> single-cycle MemWrite.
- beq with Igual=1 -> PCwrite=1, PCSource=1; same instruction with Igual=0 -> PCwrite=0; bne gives the inverse results.
- OPCODE 0x3f -> EXC_SAVE with EPCWrite=1, then Exception=1 and IorD=1 through the read, then PCSource=4 and PCwrite=1; ADDI with Overflow=1 -> same path with Exception=2.
- MEM_LAT=1 build -> FETCH_WAIT lasts 1 cycle; full add instruction completes in 5 cycles.
